wired_lsu_stq: RTL and testbench
================================

WIRED_LSU_STQ -- requirements
Module: wired_lsu_stq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of store-queue entries; power of two, 2..32.
REQ-002 SHALL have parameter FWD_EN, default 1; when 0, forwarding outputs are tied to 0.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1, discard all uncommitted entries.
REQ-006 SHALL have port enq_valid_i, input, 1, enqueue request.
REQ-007 SHALL have port enq_ready_o, output, 1, queue can accept an enqueue.
REQ-008 SHALL have enqueue payload inputs: enq_paddr_i 32, enq_strb_i 4, enq_wdata_i 32 (already lane-aligned), enq_uncached_i 1.
REQ-009 SHALL have port commit_i, input, 1, retire the oldest uncommitted entry.
REQ-010 SHALL have port drain_valid_o, output, 1, oldest committed entry presented for write.
REQ-011 SHALL have port drain_ready_i, input, 1, cache/bus accepted the write.
REQ-012 SHALL have drain payload outputs: drain_paddr_o 32, drain_strb_o 4, drain_wdata_o 32, drain_uncached_o 1.
REQ-013 SHALL have fwd_paddr_i, input, 32, load lookup address.
REQ-014 SHALL have forwarding outputs: fwd_hit_o 1, fwd_strb_o 4, fwd_data_o 32, fwd_stall_o 1.
REQ-015 SHALL have status outputs: count_o $clog2(DEPTH)+1, empty_o 1, ncmt_o $clog2(DEPTH)+1 (uncommitted count).

Function
REQ-016 SHALL keep three pointers, each $clog2(DEPTH)+1 bits wide with a wrap bit: head (oldest), cmt (first uncommitted), tail (next free); ordering invariant head <= cmt <= tail, modulo wrap.
REQ-017 SHALL define count = tail-head and full = (count == DEPTH); enq_ready_o = !full && !flush_i.
REQ-018 SHALL write the entry at tail and increment tail on enq_valid_i && enq_ready_o; latency 1 cycle.
REQ-019 SHALL increment cmt on commit_i when cmt != tail; commit_i with no uncommitted entry SHALL be ignored.
REQ-020 SHALL drive drain_valid_o = (head != cmt) with the payload of entry head; the handshake increments head.
REQ-021 SHALL hold drain payload stable while drain_valid_o && !drain_ready_i.
REQ-022 On flush_i, SHALL set tail <= cmt_next, where cmt_next includes a same-cycle commit_i, and drop any same-cycle enqueue; draining continues unaffected.
REQ-023 SHALL allow enqueue, commit and drain in the same cycle; when full, a same-cycle drain does not admit an enqueue (ready is not fed through from drain).
REQ-024 SHALL let forwarding match entries in [head, tail) with paddr[31:2] == fwd_paddr_i[31:2] and uncached == 0; the lookup is combinational and ignores same-cycle enqueue.
REQ-025 SHALL produce fwd_data_o and fwd_strb_o per byte lane from the youngest matching entry whose strb bit is set; fwd_hit_o = |fwd_strb_o.
REQ-026 SHALL assert fwd_stall_o when any uncached entry in [head, tail) matches paddr[31:2], or when more than one entry matches.
REQ-027 SHALL set empty_o = (head == tail), count_o = count and ncmt_o = tail-cmt, all registered-pointer-derived.
REQ-028 SHALL handle pointer wrap with no lost or duplicate entries across the DEPTH boundary.

Reset
REQ-029 While rst_n == 0 at posedge clk, SHALL clear all pointers to 0; then enq_ready_o=1, drain_valid_o=0, empty_o=1, count_o=0, ncmt_o=0, fwd_hit_o=0, fwd_stall_o=0.
REQ-030 Reset mid-drain SHALL drop all entries, including committed ones; entry payload storage SHALL need no reset.

Verification
REQ-031 Enqueue 8 stores with DEPTH=8 -> enq_ready_o=0 and count_o=8; one commit plus a drain handshake -> count_o=7 and enq_ready_o=1 the next cycle.
REQ-032 Enqueue A(0x1000, strb 0011, 0x0000BEEF) then B(0x1000, strb 0110, 0x00CAFE00); lookup 0x1002 -> fwd_strb_o=0111, fwd_data_o=0x00CAFEEF, fwd_stall_o=1 (multi-match).
REQ-033 Enqueue 3 entries, commit 1, then flush_i -> tail=cmt, ncmt_o=0, count_o=1, drain_valid_o stays 1 until the single drain handshake completes.
REQ-034 commit_i and flush_i in the same cycle with 2 uncommitted entries -> 1 entry survives as committed and 1 is discarded.
REQ-035 Run 20 enqueue/commit/drain cycles with DEPTH=4 and random drain_ready_i -> drain order matches enqueue order across wrap, with no stall while the payload is held.
REQ-036 Uncached entry at 0x2000 and lookup 0x2003 -> fwd_stall_o=1, fwd_hit_o=0.

Source files
------------

// File: rtl/wired_lsu_stq.sv
// Store queue: in-order enqueue, commit marks entries ready to drain,
// drain writes them out oldest-first; flush drops everything not yet
// committed. Loads look up the queue combinationally for store forwarding.
module wired_lsu_stq #(
  parameter int DEPTH  = 8,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [31:0]                enq_paddr_i,
  input  logic [3:0]                 enq_strb_i,
  input  logic [31:0]                enq_wdata_i,
  input  logic                       enq_uncached_i,
  input  logic                       commit_i,
  output logic                       drain_valid_o,
  input  logic                       drain_ready_i,
  output logic [31:0]                drain_paddr_o,
  output logic [3:0]                 drain_strb_o,
  output logic [31:0]                drain_wdata_o,
  output logic                       drain_uncached_o,
  input  logic [31:0]                fwd_paddr_i,
  output logic                       fwd_hit_o,
  output logic [3:0]                 fwd_strb_o,
  output logic [31:0]                fwd_data_o,
  output logic                       fwd_stall_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     ncmt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [PW-1:0] count;
  logic          full, enq_fire, commit_fire, drain_fire;

  // Entry payload; never reset, validity comes only from the pointers.
  logic [31:0] paddr_q [DEPTH];
  logic [3:0]  strb_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic        unc_q   [DEPTH];

  assign count       = tail_q - head_q;
  assign full        = (count == PW'(DEPTH));
  assign enq_ready_o = !full && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign commit_fire = commit_i && (cmt_q != tail_q);
  assign drain_valid_o = (head_q != cmt_q);
  assign drain_fire  = drain_valid_o && drain_ready_i;

  // Next-pointer logic; flush pulls tail back to the post-commit boundary.
  always_comb begin
    head_d = head_q + PW'(drain_fire);
    cmt_d  = cmt_q + PW'(commit_fire);
    tail_d = flush_i ? cmt_d : tail_q + PW'(enq_fire);
  end

  // Pointer registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  // Payload write at tail on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      paddr_q[tail_q[AW-1:0]] <= enq_paddr_i;
      strb_q[tail_q[AW-1:0]]  <= enq_strb_i;
      wdata_q[tail_q[AW-1:0]] <= enq_wdata_i;
      unc_q[tail_q[AW-1:0]]   <= enq_uncached_i;
    end
  end

  // Head entry is read straight from storage, so it is stable until head moves.
  assign drain_paddr_o    = paddr_q[head_q[AW-1:0]];
  assign drain_strb_o     = strb_q[head_q[AW-1:0]];
  assign drain_wdata_o    = wdata_q[head_q[AW-1:0]];
  assign drain_uncached_o = unc_q[head_q[AW-1:0]];

  assign count_o = count;
  assign empty_o = (head_q == tail_q);
  assign ncmt_o  = tail_q - cmt_q;

  logic [3:0]    f_strb;
  logic [31:0]   f_data;
  logic          f_stall, seen;
  logic [AW-1:0] idx;

  // Forwarding scan in age order (oldest first) so younger lanes overwrite.
  always_comb begin
    f_strb  = '0;
    f_data  = '0;
    f_stall = 1'b0;
    seen    = 1'b0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q[AW-1:0] + AW'(k);
      if ((PW'(k) < count) && (paddr_q[idx][31:2] == fwd_paddr_i[31:2])) begin
        if (seen || unc_q[idx]) f_stall = 1'b1;
        seen = 1'b1;
        if (!unc_q[idx]) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_q[idx][b]) begin
              f_strb[b]       = 1'b1;
              f_data[8*b +: 8] = wdata_q[idx][8*b +: 8];
            end
          end
        end
      end
    end
    if (!FWD_EN) begin
      f_strb  = '0;
      f_data  = '0;
      f_stall = 1'b0;
    end
  end

  assign fwd_strb_o  = f_strb;
  assign fwd_data_o  = f_data;
  assign fwd_stall_o = f_stall;
  assign fwd_hit_o   = |f_strb;

  // Byte offset of the lookup address is irrelevant to a word match.
  logic unused_ok;
  assign unused_ok = &{1'b0, fwd_paddr_i[1:0]};
endmodule

// File: tb/tb_wired_lsu_stq.sv
// Bench for wired_lsu_stq: a DEPTH=8 instance for directed scenarios and a
// DEPTH=4 instance for randomized wrap traffic, both on shared inputs.
module tb_wired_lsu_stq;
  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        u;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
  logic enq_valid_i = 1'b0, enq_uncached_i = 1'b0, commit_i = 1'b0, drain_ready_i = 1'b0;
  logic [31:0] enq_paddr_i = '0, enq_wdata_i = '0, fwd_paddr_i = '0;
  logic [3:0]  enq_strb_i = '0;

  logic enq_ready_o, drain_valid_o, drain_uncached_o, fwd_hit_o, fwd_stall_o, empty_o;
  logic [31:0] drain_paddr_o, drain_wdata_o, fwd_data_o;
  logic [3:0]  drain_strb_o, fwd_strb_o, count_o, ncmt_o;

  logic d4_enq_ready, d4_drain_valid, d4_drain_unc, d4_fwd_hit, d4_fwd_stall, d4_empty;
  logic [31:0] d4_drain_paddr, d4_drain_wdata, d4_fwd_data;
  logic [3:0]  d4_drain_strb, d4_fwd_strb;
  logic [2:0]  d4_count, d4_ncmt;

  int pass_cnt = 0, chk_cnt = 0;
  ent_t sb[$];
  ent_t sb4[$];

  always #5 clk = ~clk;

  wired_lsu_stq #(.DEPTH(8), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_paddr_i(enq_paddr_i), .enq_strb_i(enq_strb_i), .enq_wdata_i(enq_wdata_i),
    .enq_uncached_i(enq_uncached_i), .commit_i(commit_i),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .drain_paddr_o(drain_paddr_o), .drain_strb_o(drain_strb_o),
    .drain_wdata_o(drain_wdata_o), .drain_uncached_o(drain_uncached_o),
    .fwd_paddr_i(fwd_paddr_i), .fwd_hit_o(fwd_hit_o), .fwd_strb_o(fwd_strb_o),
    .fwd_data_o(fwd_data_o), .fwd_stall_o(fwd_stall_o),
    .count_o(count_o), .empty_o(empty_o), .ncmt_o(ncmt_o)
  );

  wired_lsu_stq #(.DEPTH(4), .FWD_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(d4_enq_ready),
    .enq_paddr_i(enq_paddr_i), .enq_strb_i(enq_strb_i), .enq_wdata_i(enq_wdata_i),
    .enq_uncached_i(enq_uncached_i), .commit_i(commit_i),
    .drain_valid_o(d4_drain_valid), .drain_ready_i(drain_ready_i),
    .drain_paddr_o(d4_drain_paddr), .drain_strb_o(d4_drain_strb),
    .drain_wdata_o(d4_drain_wdata), .drain_uncached_o(d4_drain_unc),
    .fwd_paddr_i(fwd_paddr_i), .fwd_hit_o(d4_fwd_hit), .fwd_strb_o(d4_fwd_strb),
    .fwd_data_o(d4_fwd_data), .fwd_stall_o(d4_fwd_stall),
    .count_o(d4_count), .empty_o(d4_empty), .ncmt_o(d4_ncmt)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0; commit_i = 1'b0;
    drain_ready_i = 1'b0; enq_uncached_i = 1'b0; fwd_paddr_i = '0;
    sb.delete(); sb4.delete();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // One accepted enqueue on the DEPTH=8 instance, recorded in the scoreboard.
  task automatic enq(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic u);
    enq_valid_i = 1'b1; enq_paddr_i = a; enq_strb_i = s; enq_wdata_i = d; enq_uncached_i = u;
    sb.push_back('{a: a, s: s, d: d, u: u});
    cyc();
    enq_valid_i = 1'b0; enq_uncached_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    chk_cnt++; if (enq_ready_o !== 1'b1) $display("FAIL rst_ready got %b want 1", enq_ready_o); else pass_cnt++;
    chk_cnt++; if (drain_valid_o !== 1'b0) $display("FAIL rst_dvalid got %b want 0", drain_valid_o); else pass_cnt++;
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL rst_empty got %b want 1", empty_o); else pass_cnt++;
    chk_cnt++; if (count_o !== 4'd0) $display("FAIL rst_count got %0d want 0", count_o); else pass_cnt++;
    chk_cnt++; if (ncmt_o !== 4'd0) $display("FAIL rst_ncmt got %0d want 0", ncmt_o); else pass_cnt++;
    chk_cnt++; if ({fwd_hit_o, fwd_stall_o} !== 2'b00) $display("FAIL rst_fwd got %b want 00", {fwd_hit_o, fwd_stall_o}); else pass_cnt++;
  endtask

  task automatic test_full();
    ent_t e;
    do_reset();
    for (int i = 0; i < 8; i++) enq(32'h100 + 32'(i * 4), 4'hF, 32'h1111_1111 * 32'(i + 1), 1'b0);
    @(negedge clk);
    chk_cnt++; if (count_o !== 4'd8) $display("FAIL full_count got %0d want 8", count_o); else pass_cnt++;
    chk_cnt++; if (enq_ready_o !== 1'b0) $display("FAIL full_ready got %b want 0", enq_ready_o); else pass_cnt++;
    chk_cnt++; if (ncmt_o !== 4'd8) $display("FAIL full_ncmt got %0d want 8", ncmt_o); else pass_cnt++;
    cyc();
    commit_i = 1'b1; drain_ready_i = 1'b1;
    cyc();
    commit_i = 1'b0; enq_valid_i = 1'b1; enq_paddr_i = 32'hDEAD_0000;
    @(negedge clk);
    e = sb.pop_front();
    chk_cnt++; if (enq_ready_o !== 1'b0) $display("FAIL full_drain_ready got %b want 0", enq_ready_o); else pass_cnt++;
    chk_cnt++; if (drain_valid_o !== 1'b1) $display("FAIL full_dvalid got %b want 1", drain_valid_o); else pass_cnt++;
    chk_cnt++; if ({drain_paddr_o, drain_wdata_o} !== {e.a, e.d}) $display("FAIL full_dpayload got %h/%h want %h/%h", drain_paddr_o, drain_wdata_o, e.a, e.d); else pass_cnt++;
    cyc();
    enq_valid_i = 1'b0; drain_ready_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if (count_o !== 4'd7) $display("FAIL after_drain_count got %0d want 7", count_o); else pass_cnt++;
    chk_cnt++; if (enq_ready_o !== 1'b1) $display("FAIL after_drain_ready got %b want 1", enq_ready_o); else pass_cnt++;
    chk_cnt++; if (drain_valid_o !== 1'b0) $display("FAIL after_drain_dvalid got %b want 0", drain_valid_o); else pass_cnt++;
    // reset with committed/uncommitted entries must drop all of them
    cyc();
    commit_i = 1'b1; cyc(); commit_i = 1'b0;
    do_reset();
    @(negedge clk);
    chk_cnt++; if ({drain_valid_o, empty_o, count_o} !== {1'b0, 1'b1, 4'd0}) $display("FAIL midreset got %b%b%0d want 0 1 0", drain_valid_o, empty_o, count_o); else pass_cnt++;
  endtask

  task automatic test_fwd();
    do_reset();
    enq(32'h1000, 4'b0011, 32'h0000_BEEF, 1'b0);
    fwd_paddr_i = 32'h1000;
    #1;
    chk_cnt++; if (fwd_strb_o !== 4'b0011) $display("FAIL fwd1_strb got %b want 0011", fwd_strb_o); else pass_cnt++;
    chk_cnt++; if (fwd_data_o !== 32'h0000_BEEF) $display("FAIL fwd1_data got %h want 0000beef", fwd_data_o); else pass_cnt++;
    chk_cnt++; if ({fwd_hit_o, fwd_stall_o} !== 2'b10) $display("FAIL fwd1_hs got %b want 10", {fwd_hit_o, fwd_stall_o}); else pass_cnt++;
    cyc();
    enq(32'h1000, 4'b0110, 32'h00CA_FE00, 1'b0);
    fwd_paddr_i = 32'h1002;
    #1;
    chk_cnt++; if (fwd_strb_o !== 4'b0111) $display("FAIL fwd2_strb got %b want 0111", fwd_strb_o); else pass_cnt++;
    chk_cnt++; if (fwd_data_o !== 32'h00CA_FEEF) $display("FAIL fwd2_data got %h want 00cafeef", fwd_data_o); else pass_cnt++;
    chk_cnt++; if ({fwd_hit_o, fwd_stall_o} !== 2'b11) $display("FAIL fwd2_hs got %b want 11", {fwd_hit_o, fwd_stall_o}); else pass_cnt++;
    fwd_paddr_i = 32'h1004;
    #1;
    chk_cnt++; if ({fwd_hit_o, fwd_stall_o, fwd_strb_o} !== 6'b0) $display("FAIL fwd_miss got %b want 000000", {fwd_hit_o, fwd_stall_o, fwd_strb_o}); else pass_cnt++;
  endtask

  task automatic test_flush();
    ent_t e;
    do_reset();
    enq(32'h3000, 4'hF, 32'hA0A0_A0A0, 1'b0);
    enq(32'h3004, 4'hF, 32'hB1B1_B1B1, 1'b0);
    enq(32'h3008, 4'hF, 32'hC2C2_C2C2, 1'b0);
    commit_i = 1'b1; cyc(); commit_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk_cnt++; if (enq_ready_o !== 1'b0) $display("FAIL flush_ready got %b want 0", enq_ready_o); else pass_cnt++;
    cyc();
    flush_i = 1'b0;
    sb = sb[0:0];
    @(negedge clk);
    e = sb.pop_front();
    chk_cnt++; if (ncmt_o !== 4'd0) $display("FAIL flush_ncmt got %0d want 0", ncmt_o); else pass_cnt++;
    chk_cnt++; if (count_o !== 4'd1) $display("FAIL flush_count got %0d want 1", count_o); else pass_cnt++;
    chk_cnt++; if (drain_valid_o !== 1'b1) $display("FAIL flush_dvalid got %b want 1", drain_valid_o); else pass_cnt++;
    cyc();
    @(negedge clk);
    chk_cnt++; if ({drain_valid_o, drain_wdata_o} !== {1'b1, e.d}) $display("FAIL flush_hold got %b/%h want 1/%h", drain_valid_o, drain_wdata_o, e.d); else pass_cnt++;
    cyc();
    drain_ready_i = 1'b1; cyc(); drain_ready_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({drain_valid_o, empty_o} !== 2'b01) $display("FAIL flush_drained got %b want 01", {drain_valid_o, empty_o}); else pass_cnt++;
  endtask

  task automatic test_commit_flush();
    ent_t e;
    do_reset();
    enq(32'h4000, 4'h3, 32'h0000_1234, 1'b0);
    enq(32'h4004, 4'hC, 32'h5678_0000, 1'b0);
    commit_i = 1'b1; flush_i = 1'b1;
    cyc();
    commit_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    e = sb[0];
    chk_cnt++; if ({count_o, ncmt_o} !== {4'd1, 4'd0}) $display("FAIL cf_counts got %0d/%0d want 1/0", count_o, ncmt_o); else pass_cnt++;
    chk_cnt++; if ({drain_valid_o, drain_paddr_o, drain_strb_o} !== {1'b1, e.a, e.s}) $display("FAIL cf_drain got %b/%h/%b want 1/%h/%b", drain_valid_o, drain_paddr_o, drain_strb_o, e.a, e.s); else pass_cnt++;
    cyc();
    drain_ready_i = 1'b1; cyc(); drain_ready_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if (empty_o !== 1'b1) $display("FAIL cf_empty got %b want 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_uncached();
    do_reset();
    enq(32'h2000, 4'hF, 32'h1234_5678, 1'b1);
    fwd_paddr_i = 32'h2003;
    #1;
    chk_cnt++; if ({fwd_stall_o, fwd_hit_o} !== 2'b10) $display("FAIL unc_fwd got %b want 10", {fwd_stall_o, fwd_hit_o}); else pass_cnt++;
    cyc();
    commit_i = 1'b1; cyc(); commit_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({drain_valid_o, drain_uncached_o} !== 2'b11) $display("FAIL unc_drain got %b want 11", {drain_valid_o, drain_uncached_o}); else pass_cnt++;
  endtask

  // Random traffic on the DEPTH=4 instance against a small occupancy model.
  task automatic test_wrap();
    ent_t e;
    int ncmt_m, cmtd_m, cnt_m, drained;
    logic hold;
    logic [31:0] hold_a, hold_d;
    logic ef, cf, df;
    do_reset();
    ncmt_m = 0; cmtd_m = 0; drained = 0; hold = 1'b0; hold_a = '0; hold_d = '0;
    for (int i = 0; i < 20; i++) begin
      enq_valid_i   = ($urandom_range(0, 3) != 0);
      enq_paddr_i   = $urandom & 32'hFFFF_FFFC;
      enq_wdata_i   = $urandom;
      enq_strb_i    = 4'($urandom_range(1, 15));
      commit_i      = ($urandom_range(0, 1) == 1);
      drain_ready_i = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      cnt_m = ncmt_m + cmtd_m;
      chk_cnt++; if (d4_count !== 3'(cnt_m)) $display("FAIL wrap_count[%0d] got %0d want %0d", i, d4_count, cnt_m); else pass_cnt++;
      chk_cnt++; if (d4_enq_ready !== (cnt_m != 4)) $display("FAIL wrap_ready[%0d] got %b want %b", i, d4_enq_ready, cnt_m != 4); else pass_cnt++;
      chk_cnt++; if (d4_drain_valid !== (cmtd_m > 0)) $display("FAIL wrap_dvalid[%0d] got %b want %b", i, d4_drain_valid, cmtd_m > 0); else pass_cnt++;
      if (hold) begin
        chk_cnt++; if ({d4_drain_paddr, d4_drain_wdata} !== {hold_a, hold_d}) $display("FAIL wrap_hold[%0d] got %h/%h want %h/%h", i, d4_drain_paddr, d4_drain_wdata, hold_a, hold_d); else pass_cnt++;
      end
      ef = enq_valid_i && (cnt_m != 4);
      cf = commit_i && (ncmt_m > 0);
      df = (cmtd_m > 0) && drain_ready_i;
      if (df) begin
        e = sb4.pop_front();
        drained++;
        chk_cnt++; if ({d4_drain_paddr, d4_drain_strb, d4_drain_wdata} !== {e.a, e.s, e.d}) $display("FAIL wrap_order[%0d] got %h/%b/%h want %h/%b/%h", i, d4_drain_paddr, d4_drain_strb, d4_drain_wdata, e.a, e.s, e.d); else pass_cnt++;
      end
      hold = (cmtd_m > 0) && !drain_ready_i;
      hold_a = d4_drain_paddr; hold_d = d4_drain_wdata;
      if (ef) sb4.push_back('{a: enq_paddr_i, s: enq_strb_i, d: enq_wdata_i, u: 1'b0});
      ncmt_m = ncmt_m + int'(ef) - int'(cf);
      cmtd_m = cmtd_m + int'(cf) - int'(df);
      cyc();
    end
    // Commit and drain everything left; bounded so a stuck queue still ends.
    enq_valid_i = 1'b0; commit_i = 1'b1; drain_ready_i = 1'b1;
    for (int i = 0; i < 20 && sb4.size() > 0; i++) begin
      @(negedge clk);
      if (d4_drain_valid) begin
        e = sb4.pop_front();
        drained++;
        chk_cnt++; if ({d4_drain_paddr, d4_drain_wdata} !== {e.a, e.d}) $display("FAIL wrap_tail_order got %h/%h want %h/%h", d4_drain_paddr, d4_drain_wdata, e.a, e.d); else pass_cnt++;
      end
      cyc();
    end
    commit_i = 1'b0; drain_ready_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if (sb4.size() != 0 || d4_empty !== 1'b1) $display("FAIL wrap_leftover got %0d/%b want 0/1", sb4.size(), d4_empty); else pass_cnt++;
    chk_cnt++; if (drained < 5) $display("FAIL wrap_volume got %0d want >=5", drained); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full();
    test_fwd();
    test_flush();
    test_commit_flush();
    test_uncached();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
